// File: rtl/reg4_pkg.sv
// Shared constants for the reg4 storage register.
package reg4_pkg;

   localparam int unsigned REG4_WIDTH = 4;

endpackage : reg4_pkg

// File: rtl/reg4_bit.sv
// One bit of reg4: a synchronously cleared, load-enabled flop with a tri-state output driver.
module reg4_bit (
   input  logic clk,
   input  logic clr_i,
   input  logic inen_i,
   input  logic oen_i,
   input  logic d_i,
   output logic q_o
);

   logic bit_d;
   logic bit_q;

   // Clear takes priority over load; otherwise hold.
   always_comb begin
      bit_d = bit_q;
      if (clr_i) begin
         bit_d = 1'b0;
      end else if (inen_i) begin
         bit_d = d_i;
      end
   end

   always_ff @(posedge clk) begin
      bit_q <= bit_d;
   end

   // The driver is combinational so oen acts without waiting for a clock edge.
   assign q_o = oen_i ? bit_q : 1'bz;

endmodule : reg4_bit

// File: rtl/reg4.sv
// WIDTH-bit storage register with synchronous clear, load enable and tri-state output.
module reg4
   import reg4_pkg::*;
#(
   parameter int unsigned WIDTH = REG4_WIDTH
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [WIDTH-1:0] data_in,
   input  logic             inen,
   input  logic             oen,
   output logic [WIDTH-1:0] data_out
);

   for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
      reg4_bit u_bit (
         .clk    (clk),
         .clr_i  (clr),
         .inen_i (inen),
         .oen_i  (oen),
         .d_i    (data_in[i]),
         .q_o    (data_out[i])
      );
   end

endmodule : reg4

// File: tb/tb_reg4.sv
// Self-checking bench for reg4: directed scenarios plus randomized traffic against a behavioural model.
module tb_reg4;
   import reg4_pkg::*;

   localparam int unsigned W = REG4_WIDTH;

   logic          clk = 1'b0;
   logic          clr;
   logic          inen;
   logic          oen;
   logic [W-1:0]  data_in;
   wire  [W-1:0]  data_out;

   logic [W-1:0]  q_m;
   logic [W-1:0]  exp_v;
   int            n_checks = 0;
   int            n_fail   = 0;

   reg4 #(.WIDTH(W)) dut (
      .clk      (clk),
      .clr      (clr),
      .data_in  (data_in),
      .inen     (inen),
      .oen      (oen),
      .data_out (data_out)
   );

   // Rising edges at 50, 150, 250, ... ns.
   initial begin
      forever begin
         #50 clk = 1'b1;
         #50 clk = 1'b0;
      end
   end

   function automatic logic [W-1:0] visible(input logic en, input logic [W-1:0] q);
      logic [W-1:0] zz;
      zz = 'z;
      return en ? q : zz;
   endfunction

   // Apply inputs at the falling edge, advance the model at the rising edge, settle 1 ns.
   task automatic step(input logic c, input logic ie, input logic [W-1:0] d);
      @(negedge clk);
      clr     = c;
      inen    = ie;
      data_in = d;
      @(posedge clk);
      if (c)       q_m = '0;
      else if (ie) q_m = d;
      #1;
   endtask

   task automatic test_reset();
      clr = 1'b1; inen = 1'b0; oen = 1'b1; data_in = W'(4'b0101);
      @(posedge clk);
      q_m = '0;
      #1;
      n_checks++;
      if (data_out !== W'(4'b0000)) begin
         n_fail++;
         $display("FAIL reset_zero: got %b expected %b", data_out, W'(4'b0000));
      end
      oen = 1'b0;
      #1;
      exp_v = visible(1'b0, q_m);
      n_checks++;
      if (data_out !== exp_v) begin
         n_fail++;
         $display("FAIL reset_oen_off: got %b expected %b", data_out, exp_v);
      end
      oen = 1'b1;
   endtask

   task automatic test_load();
      step(1'b0, 1'b0, W'(4'b0101));
      n_checks++;
      if (data_out !== W'(4'b0000)) begin
         n_fail++;
         $display("FAIL load_no_inen: got %b expected %b", data_out, W'(4'b0000));
      end
      step(1'b0, 1'b1, W'(4'b0101));
      n_checks++;
      if (data_out !== W'(4'b0101)) begin
         n_fail++;
         $display("FAIL load_0101: got %b expected %b", data_out, W'(4'b0101));
      end
      step(1'b0, 1'b1, W'(4'b1101));
      n_checks++;
      if (data_out !== W'(4'b1101)) begin
         n_fail++;
         $display("FAIL load_1101: got %b expected %b", data_out, W'(4'b1101));
      end
   endtask

   task automatic test_hold();
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 1'b0, W'(4'b0011));
         n_checks++;
         if (data_out !== W'(4'b1101)) begin
            n_fail++;
            $display("FAIL hold_%0d: got %b expected %b", i, data_out, W'(4'b1101));
         end
      end
   endtask

   task automatic test_oen();
      #5 oen = 1'b0;
      #1;
      exp_v = visible(1'b0, q_m);
      n_checks++;
      if (data_out !== exp_v) begin
         n_fail++;
         $display("FAIL oen_off: got %b expected %b", data_out, exp_v);
      end
      #5 oen = 1'b1;
      #1;
      n_checks++;
      if (data_out !== W'(4'b1101)) begin
         n_fail++;
         $display("FAIL oen_on: got %b expected %b", data_out, W'(4'b1101));
      end
      // oen low across an edge must not disturb the stored word.
      oen = 1'b0;
      step(1'b0, 1'b0, W'(4'b0110));
      oen = 1'b1;
      #1;
      n_checks++;
      if (data_out !== W'(4'b1101)) begin
         n_fail++;
         $display("FAIL oen_keeps_q: got %b expected %b", data_out, W'(4'b1101));
      end
   endtask

   task automatic test_clr_priority();
      step(1'b1, 1'b1, W'(4'b1111));
      n_checks++;
      if (data_out !== W'(4'b0000)) begin
         n_fail++;
         $display("FAIL clr_over_inen: got %b expected %b", data_out, W'(4'b0000));
      end
      step(1'b0, 1'b1, W'(4'b1010));
      n_checks++;
      if (data_out !== W'(4'b1010)) begin
         n_fail++;
         $display("FAIL reload_after_clr: got %b expected %b", data_out, W'(4'b1010));
      end
      step(1'b1, 1'b0, W'(4'b1010));
      n_checks++;
      if (data_out !== W'(4'b0000)) begin
         n_fail++;
         $display("FAIL clr_midrun: got %b expected %b", data_out, W'(4'b0000));
      end
      step(1'b0, 1'b1, W'(4'b0110));
      n_checks++;
      if (data_out !== W'(4'b0110)) begin
         n_fail++;
         $display("FAIL resume_after_clr: got %b expected %b", data_out, W'(4'b0110));
      end
   endtask

   task automatic test_random();
      logic          c;
      logic          ie;
      logic [W-1:0]  d;
      for (int i = 0; i < 60; i++) begin
         c  = ($urandom_range(7) == 0);
         ie = 1'($urandom_range(1));
         d  = W'($urandom);
         oen = 1'($urandom_range(3) != 0);
         step(c, ie, d);
         exp_v = visible(oen, q_m);
         n_checks++;
         if (data_out !== exp_v) begin
            n_fail++;
            $display("FAIL rand_edge_%0d: got %b expected %b", i, data_out, exp_v);
         end
         // Mid-cycle data_in and oen changes.
         #10 data_in = W'($urandom);
         inen = 1'($urandom_range(1));
         #10;
         n_checks++;
         if (data_out !== exp_v) begin
            n_fail++;
            $display("FAIL rand_mid_data_%0d: got %b expected %b", i, data_out, exp_v);
         end
         oen = ~oen;
         #1;
         exp_v = visible(oen, q_m);
         n_checks++;
         if (data_out !== exp_v) begin
            n_fail++;
            $display("FAIL rand_oen_%0d: got %b expected %b", i, data_out, exp_v);
         end
      end
   endtask

   initial begin
      q_m = 'x;
      test_reset();
      test_load();
      test_hold();
      test_oen();
      test_clr_priority();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_reg4
